// File: rtl/rvh_l1d_amo_ctrl_pkg.sv
// Shared types and constants for the L1D atomic-memory-operation sequencer.
// AMO opcodes, ALU opcodes, widths and small datapath helpers.
package rvh_l1d_amo_ctrl_pkg;

  localparam int XLEN         = 64;
  localparam int PADDR_W      = 56;
  localparam int ID_W         = 8;
  localparam int AMO_OP_WIDTH = 4;
  localparam int ALU_OP_WIDTH = 4;

  typedef enum logic [AMO_OP_WIDTH-1:0] {
    AMO_SWAP = 4'd0,
    AMO_ADD  = 4'd1,
    AMO_AND  = 4'd2,
    AMO_OR   = 4'd3,
    AMO_XOR  = 4'd4,
    AMO_MIN  = 4'd5,
    AMO_MAX  = 4'd6,
    AMO_MINU = 4'd7,
    AMO_MAXU = 4'd8,
    AMO_LR   = 4'd9,
    AMO_SC   = 4'd10
  } amo_op_e;

  typedef enum logic [ALU_OP_WIDTH-1:0] {
    ALU_ADD  = 4'd0,
    ALU_AND  = 4'd1,
    ALU_OR   = 4'd2,
    ALU_XOR  = 4'd3,
    ALU_SLT  = 4'd4,
    ALU_SLTU = 4'd5
  } alu_op_e;

  // Min/max only need the less-than flag from the ALU; swap/LR/SC ignore it.
  function automatic alu_op_e amo2alu(amo_op_e op);
    case (op)
      AMO_AND:            return ALU_AND;
      AMO_OR:             return ALU_OR;
      AMO_XOR:            return ALU_XOR;
      AMO_MIN, AMO_MAX:   return ALU_SLT;
      AMO_MINU, AMO_MAXU: return ALU_SLTU;
      default:            return ALU_ADD;
    endcase
  endfunction

  function automatic logic [XLEN-1:0] sext32(logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction

  function automatic logic [7:0] wr_mask(logic w, logic hi);
    if (!w) return 8'hFF;
    return hi ? 8'hF0 : 8'h0F;
  endfunction

endpackage

// File: rtl/rvh_l1d_amo_ctrl_if.sv
// Bundle of LSU request/response, data-array read/write and ALU ports of the AMO sequencer.
// rsv_clr_i exists only when RVH_L1D_AMO_LRSC_EN is defined.
interface rvh_l1d_amo_ctrl_if;
  import rvh_l1d_amo_ctrl_pkg::*;

  logic                    amo_req_vld_i;
  logic                    amo_req_rdy_o;
  logic [AMO_OP_WIDTH-1:0] amo_req_op_i;
  logic                    amo_req_w_i;
  logic [PADDR_W-1:0]      amo_req_addr_i;
  logic [XLEN-1:0]         amo_req_data_i;
  logic [ID_W-1:0]         amo_req_id_i;

  logic                    rd_req_vld_o;
  logic                    rd_req_rdy_i;
  logic [PADDR_W-1:0]      rd_req_addr_o;
  logic                    rd_resp_vld_i;
  logic [XLEN-1:0]         rd_resp_data_i;

  logic [ALU_OP_WIDTH-1:0] alu_opcode_o;
  logic                    alu_op_w_o;
  logic [XLEN-1:0]         alu_operand0_o;
  logic [XLEN-1:0]         alu_operand1_o;
  logic [XLEN-1:0]         alu_result_i;

  logic                    wr_req_vld_o;
  logic                    wr_req_rdy_i;
  logic [PADDR_W-1:0]      wr_req_addr_o;
  logic [XLEN-1:0]         wr_req_data_o;
  logic [7:0]              wr_req_mask_o;

  logic                    resp_vld_o;
  logic                    resp_rdy_i;
  logic [ID_W-1:0]         resp_id_o;
  logic [XLEN-1:0]         resp_data_o;

`ifdef RVH_L1D_AMO_LRSC_EN
  logic                    rsv_clr_i;
`endif

  // master: the AMO sequencer; slave: LSU, data array and ALU around it.
  modport master (
`ifdef RVH_L1D_AMO_LRSC_EN
    input  rsv_clr_i,
`endif
    input  amo_req_vld_i, amo_req_op_i, amo_req_w_i, amo_req_addr_i, amo_req_data_i, amo_req_id_i,
    input  rd_req_rdy_i, rd_resp_vld_i, rd_resp_data_i, alu_result_i, wr_req_rdy_i, resp_rdy_i,
    output amo_req_rdy_o, rd_req_vld_o, rd_req_addr_o,
    output alu_opcode_o, alu_op_w_o, alu_operand0_o, alu_operand1_o,
    output wr_req_vld_o, wr_req_addr_o, wr_req_data_o, wr_req_mask_o,
    output resp_vld_o, resp_id_o, resp_data_o
  );

  modport slave (
`ifdef RVH_L1D_AMO_LRSC_EN
    output rsv_clr_i,
`endif
    output amo_req_vld_i, amo_req_op_i, amo_req_w_i, amo_req_addr_i, amo_req_data_i, amo_req_id_i,
    output rd_req_rdy_i, rd_resp_vld_i, rd_resp_data_i, alu_result_i, wr_req_rdy_i, resp_rdy_i,
    input  amo_req_rdy_o, rd_req_vld_o, rd_req_addr_o,
    input  alu_opcode_o, alu_op_w_o, alu_operand0_o, alu_operand1_o,
    input  wr_req_vld_o, wr_req_addr_o, wr_req_data_o, wr_req_mask_o,
    input  resp_vld_o, resp_id_o, resp_data_o
  );

endinterface

// File: rtl/rvh_l1d_amo_ctrl.sv
// L1D AMO sequencer: read doubleword, combine via external ALU, write back, return old value.
// Define RVH_L1D_AMO_LRSC_EN to add the LR/SC reservation register and rsv_clr_i.
module rvh_l1d_amo_ctrl
  import rvh_l1d_amo_ctrl_pkg::*;
(
  input logic                 clk,
  input logic                 rst,
  rvh_l1d_amo_ctrl_if.master  bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_RD_REQ, S_RD_WAIT, S_EXEC, S_WR_REQ, S_RESP
  } state_e;

  state_e              state_q, state_d;
  amo_op_e             op_q;
  logic                w_q;
  logic [PADDR_W-1:2]  addr_q;
  logic [XLEN-1:0]     rs2_q, old_q, wdata_q, new_val;
  logic [7:0]          wmask_q;
  logic [ID_W-1:0]     id_q;

  amo_op_e             req_op;
  logic                req_hs, rd_cap, wr_hs, sc_ok;
  logic [31:0]         rd_word;
  logic                unused_addr_lsb;

  assign req_op          = amo_op_e'(bus.amo_req_op_i);
  assign req_hs          = (state_q == S_IDLE) && bus.amo_req_vld_i;
  assign rd_cap          = (state_q == S_RD_WAIT) && bus.rd_resp_vld_i;
  assign wr_hs           = (state_q == S_WR_REQ) && bus.wr_req_rdy_i;
  assign rd_word         = addr_q[2] ? bus.rd_resp_data_i[63:32] : bus.rd_resp_data_i[31:0];
  assign unused_addr_lsb = ^bus.amo_req_addr_i[1:0];

`ifdef RVH_L1D_AMO_LRSC_EN
  logic                 rsv_vld_q;
  logic [PADDR_W-4:0]   rsv_addr_q;

  // A kill arriving with the SC itself is honoured: the SC fails.
  assign sc_ok = rsv_vld_q && !bus.rsv_clr_i &&
                 (rsv_addr_q == bus.amo_req_addr_i[PADDR_W-1:3]);

  always_ff @(posedge clk) begin
    if (rst) begin
      rsv_vld_q  <= 1'b0;
      rsv_addr_q <= '0;
    end else begin
      if (rd_cap && op_q == AMO_LR) begin
        rsv_vld_q  <= 1'b1;
        rsv_addr_q <= addr_q[PADDR_W-1:3];
      end
      if (req_hs && req_op == AMO_SC)                 rsv_vld_q <= 1'b0;
      if (wr_hs && rsv_addr_q == addr_q[PADDR_W-1:3]) rsv_vld_q <= 1'b0;
      if (bus.rsv_clr_i)                              rsv_vld_q <= 1'b0;
    end
  end
`else
  assign sc_ok = 1'b0;
`endif

  always_comb begin
    state_d          = state_q;
    bus.rd_req_vld_o = 1'b0;
    bus.wr_req_vld_o = 1'b0;
    bus.resp_vld_o   = 1'b0;
    case (state_q)
      S_IDLE: begin
        // SC never reads: it either writes straight away or fails immediately.
        if (bus.amo_req_vld_i) begin
          if (req_op == AMO_SC) state_d = sc_ok ? S_WR_REQ : S_RESP;
          else                  state_d = S_RD_REQ;
        end
      end
      S_RD_REQ: begin
        bus.rd_req_vld_o = 1'b1;
        if (bus.rd_req_rdy_i) state_d = S_RD_WAIT;
      end
      S_RD_WAIT: if (bus.rd_resp_vld_i) state_d = (op_q == AMO_LR) ? S_RESP : S_EXEC;
      S_EXEC:    state_d = S_WR_REQ;
      S_WR_REQ: begin
        bus.wr_req_vld_o = 1'b1;
        if (bus.wr_req_rdy_i) state_d = S_RESP;
      end
      S_RESP: begin
        bus.resp_vld_o = 1'b1;
        if (bus.resp_rdy_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    new_val = bus.alu_result_i;
    case (op_q)
      AMO_SWAP:           new_val = rs2_q;
      AMO_MIN, AMO_MINU:  new_val = bus.alu_result_i[0] ? old_q : rs2_q;
      AMO_MAX, AMO_MAXU:  new_val = bus.alu_result_i[0] ? rs2_q : old_q;
      default:            new_val = bus.alu_result_i;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      op_q    <= AMO_SWAP;
      w_q     <= 1'b0;
      addr_q  <= '0;
      rs2_q   <= '0;
      old_q   <= '0;
      wdata_q <= '0;
      wmask_q <= '0;
      id_q    <= '0;
    end else begin
      state_q <= state_d;
      if (req_hs) begin
        op_q   <= req_op;
        w_q    <= bus.amo_req_w_i;
        addr_q <= bus.amo_req_addr_i[PADDR_W-1:2];
        id_q   <= bus.amo_req_id_i;
        rs2_q  <= bus.amo_req_w_i ? sext32(bus.amo_req_data_i[31:0]) : bus.amo_req_data_i;
        if (req_op == AMO_SC) begin
          old_q   <= sc_ok ? '0 : XLEN'(1);
          wdata_q <= bus.amo_req_w_i ? {2{bus.amo_req_data_i[31:0]}} : bus.amo_req_data_i;
          wmask_q <= wr_mask(bus.amo_req_w_i, bus.amo_req_addr_i[2]);
        end
      end
      if (rd_cap)
        old_q <= w_q ? sext32(rd_word) : bus.rd_resp_data_i;
      if (state_q == S_EXEC) begin
        wdata_q <= w_q ? {2{new_val[31:0]}} : new_val;
        wmask_q <= wr_mask(w_q, addr_q[2]);
      end
    end
  end

  assign bus.amo_req_rdy_o  = (state_q == S_IDLE);
  assign bus.rd_req_addr_o  = {addr_q[PADDR_W-1:3], 3'b000};
  assign bus.wr_req_addr_o  = {addr_q[PADDR_W-1:3], 3'b000};
  assign bus.wr_req_data_o  = wdata_q;
  assign bus.wr_req_mask_o  = wmask_q;
  assign bus.resp_data_o    = old_q;
  assign bus.resp_id_o      = id_q;
  assign bus.alu_opcode_o   = amo2alu(op_q);
  assign bus.alu_op_w_o     = w_q;
  assign bus.alu_operand0_o = old_q;
  assign bus.alu_operand1_o = rs2_q;

endmodule
